// File: rtl/bakraid_arb_pkg.sv
// Shared types for the Bakraid SDRAM arbiter slice.
// FSM encoding, bank count and default address width.
package bakraid_arb_pkg;

  localparam int NBANK      = 4;
  localparam int SDRAMW_DEF = 22;
  localparam int WAITW      = 7;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [NBANK-1:0] bank_oh(input bank_t b);
    return NBANK'(1) << b;
  endfunction

endpackage

// File: rtl/bakraid_rr_pick.sv
// Round-robin priority encoder over the bank read requests.
// Search starts at i_ptr inclusive and wraps through all banks.
module bakraid_rr_pick
  import bakraid_arb_pkg::*;
(
  input  logic [NBANK-1:0] i_req,
  input  bank_t            i_ptr,
  output bank_t            o_idx,
  output logic             o_vld
);

  bank_t w_k;

  // Walk from the far end so the nearest requester wins last.
  always_comb begin
    o_idx = i_ptr;
    o_vld = 1'b0;
    w_k   = i_ptr;
    for (int i = NBANK - 1; i >= 0; i--) begin
      w_k = i_ptr + bank_t'(i);
      if (i_req[w_k]) begin
        o_idx = w_k;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bakraid_sdram_arb.sv
// Four-bank read / loader write arbiter in front of one SDRAM port.
// Define BAKRAID_ARB_STARVE_EN to add per-bank starvation promotion.
module bakraid_sdram_arb
  import bakraid_arb_pkg::*;
#(
  parameter int SDRAMW     = SDRAMW_DEF,
  parameter int STARVE_MAX = 64
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic                    DOWNLOADING,
  input  logic                    PROG_WE,
  input  logic [SDRAMW-1:0]       PROG_ADDR,
  input  logic [1:0]              PROG_BA,
  input  logic [15:0]             PROG_DATA,
  input  logic [1:0]              PROG_MASK,
  output logic                    PROG_RDY,
  input  logic [NBANK-1:0]        BA_RD,
  input  logic [NBANK*SDRAMW-1:0] BA_ADDR,
  output logic [NBANK-1:0]        BA_ACK,
  output logic [NBANK-1:0]        BA_DST,
  output logic [NBANK-1:0]        BA_RDY,
  output logic                    SD_REQ,
  output logic                    SD_WE,
  output logic [1:0]              SD_BA,
  output logic [SDRAMW-1:0]       SD_ADDR,
  output logic [15:0]             SD_DIN,
  output logic [1:0]              SD_DIN_M,
  input  logic                    SD_ACK,
  input  logic                    SD_DST,
  input  logic                    SD_RDY
);

  state_t            r_state;
  state_t            w_next;
  bank_t             r_ptr;
  bank_t             r_bank;
  logic              r_we;
  logic [SDRAMW-1:0] r_addr;
  logic [15:0]       r_din;
  logic [1:0]        r_mask;

  bank_t             w_rr_idx;
  logic              w_rr_vld;
  bank_t             w_sel;
  logic              w_sel_vld;
  logic              w_idle;
  logic              w_go_wr;
  logic              w_go_rd;
  logic [NBANK-1:0]  w_oh;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_go_wr = w_idle && DOWNLOADING && PROG_WE;
  assign w_go_rd = w_idle && !DOWNLOADING && w_sel_vld;
  assign w_oh    = bank_oh(r_bank);

  bakraid_rr_pick u_rr (
    .i_req (BA_RD),
    .i_ptr (r_ptr),
    .o_idx (w_rr_idx),
    .o_vld (w_rr_vld)
  );

`ifdef BAKRAID_ARB_STARVE_EN
  localparam logic [WAITW-1:0] LP_SMAX =
    (STARVE_MAX > 127) ? 7'h7f : 7'(STARVE_MAX);

  logic [WAITW-1:0] r_wait [NBANK];
  logic [NBANK-1:0] w_hot;
  bank_t            w_hot_idx;
  logic             w_hot_vld;

  always_comb begin
    w_hot     = '0;
    w_hot_idx = '0;
    w_hot_vld = 1'b0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      w_hot[i] = BA_RD[i] && (r_wait[i] >= LP_SMAX);
      if (w_hot[i]) begin
        w_hot_idx = bank_t'(i);
        w_hot_vld = 1'b1;
      end
    end
  end

  assign w_sel     = w_hot_vld ? w_hot_idx : w_rr_idx;
  assign w_sel_vld = w_rr_vld;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NBANK; i++)
        r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (w_go_rd && (w_sel == bank_t'(i)))
          r_wait[i] <= '0;
        else if (BA_RD[i] && (r_wait[i] != 7'h7f))
          r_wait[i] <= r_wait[i] + 7'd1;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_sel        = w_rr_idx;
  assign w_sel_vld    = w_rr_vld;
  assign w_unused_cfg = (STARVE_MAX != 0);
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_go_wr || w_go_rd) w_next = ST_REQ;
      ST_REQ:  if (SD_ACK) w_next = ST_DATA;
      ST_DATA: if (SD_RDY) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshakes route only to the owner; reads never touch PROG_RDY.
  always_comb begin
    SD_REQ   = 1'b0;
    SD_WE    = 1'b0;
    BA_ACK   = '0;
    BA_DST   = '0;
    BA_RDY   = '0;
    PROG_RDY = 1'b0;
    unique case (r_state)
      ST_REQ: begin
        SD_REQ = 1'b1;
        SD_WE  = r_we;
        if (!r_we && SD_ACK)
          BA_ACK = w_oh;
      end
      ST_DATA: begin
        SD_WE = r_we;
        if (r_we) begin
          PROG_RDY = SD_RDY;
        end else begin
          if (SD_DST) BA_DST = w_oh;
          if (SD_RDY) BA_RDY = w_oh;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ptr  <= '0;
      r_bank <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
      r_mask <= '0;
    end else if (w_go_wr) begin
      r_bank <= PROG_BA;
      r_we   <= 1'b1;
      r_addr <= PROG_ADDR;
      r_din  <= PROG_DATA;
      r_mask <= PROG_MASK;
    end else if (w_go_rd) begin
      r_ptr  <= w_sel + bank_t'(1);
      r_bank <= w_sel;
      r_we   <= 1'b0;
      r_addr <= BA_ADDR[int'(w_sel)*SDRAMW +: SDRAMW];
      r_din  <= '0;
      r_mask <= '0;
    end
  end

  assign SD_BA    = r_bank;
  assign SD_ADDR  = r_addr;
  assign SD_DIN   = r_din;
  assign SD_DIN_M = r_mask;

endmodule

// File: tb/tb_bakraid_sdram_arb.sv
// Directed bench for bakraid_sdram_arb: round-robin, loader write,
// dropped request, mid-transaction reset and starvation promotion.
module tb_bakraid_sdram_arb;

  localparam int AW = 22;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          DOWNLOADING = 1'b0;
  logic          PROG_WE = 1'b0;
  logic [AW-1:0] PROG_ADDR = '0;
  logic [1:0]    PROG_BA = '0;
  logic [15:0]   PROG_DATA = '0;
  logic [1:0]    PROG_MASK = '0;
  logic          PROG_RDY;
  logic [3:0]    BA_RD = '0;
  logic [4*AW-1:0] BA_ADDR = '0;
  logic [3:0]    BA_ACK, BA_DST, BA_RDY;
  logic          SD_REQ, SD_WE;
  logic [1:0]    SD_BA;
  logic [AW-1:0] SD_ADDR;
  logic [15:0]   SD_DIN;
  logic [1:0]    SD_DIN_M;
  logic          SD_ACK = 1'b0;
  logic          SD_DST = 1'b0;
  logic          SD_RDY = 1'b0;

  int n_tot = 0;
  int n_bad = 0;

  logic [1:0]    g_ba;
  logic          g_we, g_prdy, g_held;
  logic [AW-1:0] g_addr;
  logic [15:0]   g_din;
  logic [3:0]    g_ack, g_dst, g_rdy;

  always #5 CLK = ~CLK;

  bakraid_sdram_arb #(.SDRAMW(AW), .STARVE_MAX(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .DOWNLOADING(DOWNLOADING),
    .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_BA(PROG_BA),
    .PROG_DATA(PROG_DATA), .PROG_MASK(PROG_MASK),
    .PROG_RDY(PROG_RDY), .BA_RD(BA_RD), .BA_ADDR(BA_ADDR),
    .BA_ACK(BA_ACK), .BA_DST(BA_DST), .BA_RDY(BA_RDY),
    .SD_REQ(SD_REQ), .SD_WE(SD_WE), .SD_BA(SD_BA),
    .SD_ADDR(SD_ADDR), .SD_DIN(SD_DIN), .SD_DIN_M(SD_DIN_M),
    .SD_ACK(SD_ACK), .SD_DST(SD_DST), .SD_RDY(SD_RDY)
  );

  function automatic logic [AW-1:0] addr_of(input int n);
    return 22'h100000 + AW'(n * 'h111);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  // Controller model: ACK 2 cycles and RDY 4 cycles after SD_REQ.
  task automatic serve(input bit drop);
    int n;
    n = 0;
    g_ba = '0; g_we = 1'b0; g_addr = '0; g_din = '0;
    g_ack = '0; g_dst = '0; g_rdy = '0; g_prdy = 1'b0; g_held = 1'b0;
    cyc;
    while (SD_REQ !== 1'b1 && n < 20) begin
      cyc;
      n++;
    end
    if (SD_REQ !== 1'b1) begin
      chk("req_timeout", {31'd0, SD_REQ}, 32'd1);
      return;
    end
    g_ba = SD_BA; g_we = SD_WE; g_addr = SD_ADDR; g_din = SD_DIN;
    if (drop) BA_RD = '0;
    cyc;
    cyc;
    SD_ACK = 1'b1;
    #1;
    g_ack = BA_ACK;
    g_held = SD_REQ;
    cyc;
    SD_ACK = 1'b0;
    SD_DST = 1'b1;
    #1;
    g_dst = BA_DST;
    cyc;
    SD_DST = 1'b0;
    SD_RDY = 1'b1;
    #1;
    g_rdy = BA_RDY;
    g_prdy = PROG_RDY;
    cyc;
    SD_RDY = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 4; n++)
      BA_ADDR[n*AW +: AW] = addr_of(n);

    repeat (2) cyc;
    chk("rst_req", {31'd0, SD_REQ}, 32'd0);
    chk("rst_addr", 32'(SD_ADDR), 32'd0);
    chk("rst_ba", {BA_ACK, BA_DST, BA_RDY}, 32'd0);
    chk("rst_prdy", {31'd0, PROG_RDY}, 32'd0);
    RESETn = 1'b1;
    cyc;

    SD_RDY = 1'b1;
    SD_ACK = 1'b1;
    #1;
    chk("sp_rdy", 32'(BA_RDY), 32'd0);
    chk("sp_ack", 32'(BA_ACK), 32'd0);
    chk("sp_prdy", {31'd0, PROG_RDY}, 32'd0);
    cyc;
    SD_RDY = 1'b0;
    SD_ACK = 1'b0;
    cyc;
    chk("sp_idle", {31'd0, SD_REQ}, 32'd0);

    BA_RD = 4'hF;
    for (int i = 0; i < 5; i++) begin
      serve(1'b0);
      if (i == 4) BA_RD = '0;
`ifndef BAKRAID_ARB_STARVE_EN
      chk("rr_ba", 32'(g_ba), 32'(i % 4));
      chk("rr_addr", 32'(g_addr), 32'(addr_of(i % 4)));
      chk("rr_ack", 32'(g_ack), 32'(1 << (i % 4)));
      chk("rr_dst", 32'(g_dst), 32'(1 << (i % 4)));
      chk("rr_rdy", 32'(g_rdy), 32'(1 << (i % 4)));
`endif
      chk("rr_we", {31'd0, g_we}, 32'd0);
      chk("rr_gap", {31'd0, SD_REQ}, 32'd0);
    end

    DOWNLOADING = 1'b1;
    PROG_WE = 1'b1;
    PROG_ADDR = 22'h12345;
    PROG_BA = 2'd2;
    PROG_DATA = 16'hBEEF;
    PROG_MASK = 2'b01;
    BA_RD = 4'b0001;
    serve(1'b0);
    PROG_WE = 1'b0;
    chk("wr_we", {31'd0, g_we}, 32'd1);
    chk("wr_ba", 32'(g_ba), 32'd2);
    chk("wr_addr", 32'(g_addr), 32'h12345);
    chk("wr_din", 32'(g_din), 32'hBEEF);
    chk("wr_ack", 32'(g_ack), 32'd0);
    chk("wr_rdy", 32'(g_rdy), 32'd0);
    chk("wr_prdy", {31'd0, g_prdy}, 32'd1);
    cyc;
    chk("wr_prdy_end", {31'd0, PROG_RDY}, 32'd0);
    repeat (3) cyc;
    chk("dl_block", {31'd0, SD_REQ}, 32'd0);

    DOWNLOADING = 1'b0;
    BA_RD = 4'b0100;
    serve(1'b1);
    chk("dr_ba", 32'(g_ba), 32'd2);
    chk("dr_held", {31'd0, g_held}, 32'd1);
    chk("dr_ack", 32'(g_ack), 32'b0100);
    chk("dr_rdy", 32'(g_rdy), 32'b0100);
    cyc;
    chk("dr_idle", {31'd0, SD_REQ}, 32'd0);

    BA_RD = 4'b0010;
    cyc;
    chk("rs_req", {31'd0, SD_REQ}, 32'd1);
    chk("rs_ba", 32'(SD_BA), 32'd1);
    cyc;
    SD_ACK = 1'b1;
    cyc;
    SD_ACK = 1'b0;
    BA_RD = '0;
    RESETn = 1'b0;
    #1;
    SD_RDY = 1'b1;
    #1;
    chk("rs_sd", {29'd0, SD_REQ, SD_BA}, 32'd0);
    chk("rs_addr", 32'(SD_ADDR), 32'd0);
    chk("rs_brdy", 32'(BA_RDY), 32'd0);
    cyc;
    SD_RDY = 1'b0;
    RESETn = 1'b1;
    BA_RD = 4'hF;
    serve(1'b0);
    BA_RD = '0;
    chk("rs_next", 32'(g_ba), 32'd0);

    BA_RD = 4'b1000;
    serve(1'b1);
    chk("sv_b3", 32'(g_ba), 32'd3);
    DOWNLOADING = 1'b1;
    BA_RD = 4'b1000;
    repeat (10) cyc;
    chk("sv_block", {31'd0, SD_REQ}, 32'd0);
    BA_RD = 4'b1001;
    DOWNLOADING = 1'b0;
    serve(1'b0);
    BA_RD = '0;
`ifdef BAKRAID_ARB_STARVE_EN
    chk("sv_pick", 32'(g_ba), 32'd3);
`else
    chk("sv_pick", 32'(g_ba), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
